fp_hard_clipper: RTL
====================

# fp_hard_clipper

Hard-clip distortion stage for the float audio path. Accepts one IEEE-754 single-precision sample at a time, limits it to ±threshold, and drives `fpCompareWrapper` through its `clk_en`/`done` handshake to make the decisions. Sits directly upstream of the compare unit, between the effect-chain input mux and the output gain stage. Keeps a saturating count of clipped samples for the front-panel clip LED.

## Interface
- `TIMEOUT`, default 15: maximum cycles to wait for `cmp_done` per compare before aborting.
- `CNT_W`, default 16: clip counter width.

- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  block can accept a sample; high only in IDLE
- `sample_in`  in  32  float sample
- `threshold`  in  32  float clip level; sign bit ignored (treated as +|T|)
- `out_valid`  out  1  one-cycle pulse; `sample_out` valid
- `sample_out`  out  32  clipped sample, held until the next `out_valid`
- `cmp_en`  out  1  to compare `clk_en`
- `cmp_a`, `cmp_b`  out  32 each  compare operands
- `cmp_result`  in  32  bits [2:0] = {alb, agb, aeb}; other bits ignored
- `cmp_done`  in  1  compare complete
- `clip_cnt`  out  CNT_W  saturating count of clipped samples
- `clr_cnt`  in  1  synchronous clear of `clip_cnt` and `err`
- `err`  out  1  sticky: compare timeout or unordered (NaN) result

## Operation
- States: IDLE, CMP_HI, GAP, CMP_LO, OUT.
- IDLE: `in_ready`=1. On `in_valid`, latch S=`sample_in` and T={1'b0, `threshold`[30:0]}, then go to CMP_HI.
- CMP_HI: `cmp_en`=1, `cmp_a`=S, `cmp_b`=T. Hold until `cmp_done` is sampled high.
  - If agb: result=T, increment count, go to OUT. The LO compare is skipped.
  - If bits[2:0]==0 (unordered): result=S, set `err`, go to OUT.
  - Otherwise: go to GAP.
- GAP: `cmp_en`=0 for exactly one cycle, letting the compare counter return to 0. Then go to CMP_LO.
- CMP_LO: `cmp_en`=1, `cmp_a`=S, `cmp_b`=-T (T with bit 31 set). Hold until `cmp_done` is sampled high.
  - If alb: result=-T, increment count.
  - Otherwise: result=S.
  - Go to OUT.
- OUT: load `sample_out` with result, pulse `out_valid`, return to IDLE.
- Equality (aeb) passes the sample through; S==±T is not a clip.
- Timeout: if a compare state has waited TIMEOUT cycles without `cmp_done`, set `err`, use result=S, and go to OUT with `cmp_en`=0.
- `clip_cnt` saturates at all-ones. If `clr_cnt` coincides with an increment, the clear wins and the count is 0.
- `cmp_a`, `cmp_b` and `cmp_en` change only on state transitions.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `sample_out`=0, `cmp_en`=0, `cmp_a`=`cmp_b`=0, `clip_cnt`=0, `err`=0, timeout counter 0.
- Reset asserted mid-operation: abort immediately; `cmp_en` drops asynchronously and no `out_valid` is produced.
- Let L = clock edges from `cmp_en` rising to the edge at which `cmp_done` is sampled high. L=3 with `fpCompareWrapper`.
- Acceptance edge = E0.
  - Full path: `out_valid` high in the cycle after edge E0+2L+2.
  - Positive-clip path: `out_valid` high in the cycle after edge E0+L+1.
- One sample in flight. `in_ready` returns high in the cycle after `out_valid`.

## Structure
- Shared package `fp_pkg`:
  - `FP_SIGN` = bit 31
  - `CMP_ALB`=2, `CMP_AGB`=1, `CMP_AEB`=0
  - state enum
  - `fp_neg()` (sign flip)
- One sub-module, `fp_clip_timeout`: loadable down-counter with an expiry flag, reused by other compare-driven stages.
- The `fpCompareWrapper` instance lives in the parent, not in this block.

## Test plan
- S=0.5 (0x3F000000), T=0.8 (0x3F4CCCCD), compare model L=3 → `sample_out`=0x3F000000, two compares issued, `out_valid` 8 cycles after accept, `clip_cnt`=0.
- S=1.5 (0x3FC00000), T=0.8 → `sample_out`=0x3F4CCCCD, only the HI compare issued, latency 4, `clip_cnt`=1.
- S=-1.5 (0xBFC00000), T=0.8 → `sample_out`=0xBF4CCCCD, one GAP cycle with `cmp_en`=0 between the compares, `clip_cnt`=1. S=T=0x3F4CCCCD → passthrough.
- S=NaN (0x7FC00000) → `sample_out`=0x7FC00000, `err`=1. `cmp_done` held low → `out_valid` after 15 wait cycles, `err`=1, `cmp_en`=0.
- Preload `clip_cnt`=0xFFFF, clip again → stays 0xFFFF. `clr_cnt` in the same cycle as a clip → 0.
- Assert `reset_n`=0 during CMP_LO → outputs return to reset values at once, no `out_valid`. The next sample processes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared float field positions, compare-result bit positions and clipper states.
// Ports: none (package). fp_neg() flips the sign bit of a single-precision value.
package fp_pkg;

  localparam int FP_SIGN = 31;

  // Bit positions inside the compare unit's result word.
  localparam int CMP_ALB = 2;
  localparam int CMP_AGB = 1;
  localparam int CMP_AEB = 0;

  typedef enum logic [2:0] {
    IDLE,
    CMP_HI,
    GAP,
    CMP_LO,
    OUT
  } clip_state_t;

  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    fp_neg = {~x[FP_SIGN], x[FP_SIGN-1:0]};
  endfunction

endpackage

// File: rtl/fp_hard_clipper_if.sv
// fp_hard_clipper_if: sample stream plus compare-unit handshake for the float hard clipper.
// Ports: in_valid/in_ready/sample_in/threshold in, out_valid/sample_out out,
//        cmp_en/cmp_a/cmp_b to the compare unit, cmp_result/cmp_done back from it.
interface fp_hard_clipper_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] sample_in;
  logic [31:0] threshold;
  logic        out_valid;
  logic [31:0] sample_out;
  logic        cmp_en;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [31:0] cmp_result;
  logic        cmp_done;

  // master: the clipper itself
  modport master (
    input  in_valid, sample_in, threshold, cmp_result, cmp_done,
    output in_ready, out_valid, sample_out, cmp_en, cmp_a, cmp_b
  );

  // slave: the surrounding audio path and compare unit
  modport slave (
    output in_valid, sample_in, threshold, cmp_result, cmp_done,
    input  in_ready, out_valid, sample_out, cmp_en, cmp_a, cmp_b
  );

endinterface

// File: rtl/fp_clip_timeout.sv
// fp_clip_timeout: loadable down-counter that flags when a compare has waited too long.
// Ports: clock/reset_n, load (restart at TIMEOUT-1), run (count one waited cycle),
//        expired (counter at zero; the current waited cycle is the TIMEOUT-th).
module fp_clip_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/fp_hard_clipper.sv
// fp_hard_clipper: limits a float sample to +/-|threshold| using an external compare unit.
// Ports: clock/reset_n, bus (sample handshake + compare clk_en/done), clr_cnt,
//        clip_cnt (saturating count of clipped samples), err (sticky timeout/unordered flag).
module fp_hard_clipper
  import fp_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  fp_hard_clipper_if.master bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  clip_cnt,
  output logic              err
);

  clip_state_t state_q, state_d;
  logic        cmp_en_q, cmp_en_d;
  logic [31:0] cmp_a_q, cmp_a_d;       // also serves as the latched sample S
  logic [31:0] cmp_b_q, cmp_b_d;
  logic [31:0] thr_q, thr_d;           // +|T|
  logic [31:0] res_q, res_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] sample_out_q, sample_out_d;
  logic        in_ready;
  logic        inc, set_err;
  logic        tmr_load, tmr_run, tmr_expired, timed_out;
  logic        unordered;
  logic        unused_bits;

  // Only the three flag bits of the compare result and the threshold magnitude matter.
  assign unused_bits = ^{bus.cmp_result[31:3], bus.threshold[FP_SIGN]};

  assign unordered = !(bus.cmp_result[CMP_ALB] | bus.cmp_result[CMP_AGB] |
                       bus.cmp_result[CMP_AEB]);

  // in_ready stays low during the out_valid cycle so a new sample lands one cycle later.
  assign in_ready  = (state_q == IDLE) && !out_valid_q;

  assign tmr_run   = ((state_q == CMP_HI) || (state_q == CMP_LO)) && !bus.cmp_done;
  assign timed_out = tmr_run && tmr_expired;

  fp_clip_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmp_en_d     = cmp_en_q;
    cmp_a_d      = cmp_a_q;
    cmp_b_d      = cmp_b_q;
    thr_d        = thr_q;
    res_d        = res_q;
    out_valid_d  = 1'b0;
    sample_out_d = sample_out_q;
    inc          = 1'b0;
    set_err      = 1'b0;
    tmr_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          thr_d    = {1'b0, bus.threshold[FP_SIGN-1:0]};
          cmp_a_d  = bus.sample_in;
          cmp_b_d  = {1'b0, bus.threshold[FP_SIGN-1:0]};
          cmp_en_d = 1'b1;
          tmr_load = 1'b1;
          state_d  = CMP_HI;
        end
      end
      CMP_HI: begin
        if (bus.cmp_done) begin
          cmp_en_d = 1'b0;
          if (bus.cmp_result[CMP_AGB]) begin
            res_d   = thr_q;
            inc     = 1'b1;
            state_d = OUT;
          end else if (unordered) begin
            res_d   = cmp_a_q;
            set_err = 1'b1;
            state_d = OUT;
          end else begin
            state_d = GAP;
          end
        end else if (timed_out) begin
          cmp_en_d = 1'b0;
          res_d    = cmp_a_q;
          set_err  = 1'b1;
          state_d  = OUT;
        end
      end
      GAP: begin
        // One idle cycle lets the compare unit's latency counter return to zero.
        cmp_en_d = 1'b1;
        cmp_b_d  = fp_neg(thr_q);
        tmr_load = 1'b1;
        state_d  = CMP_LO;
      end
      CMP_LO: begin
        if (bus.cmp_done) begin
          cmp_en_d = 1'b0;
          if (bus.cmp_result[CMP_ALB]) begin
            res_d = fp_neg(thr_q);
            inc   = 1'b1;
          end else begin
            res_d = cmp_a_q;
          end
          state_d = OUT;
        end else if (timed_out) begin
          cmp_en_d = 1'b0;
          res_d    = cmp_a_q;
          set_err  = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        out_valid_d  = 1'b1;
        sample_out_d = res_q;
        state_d      = IDLE;
      end
      default: begin
        cmp_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmp_en_q     <= 1'b0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      thr_q        <= '0;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      clip_cnt     <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmp_en_q     <= cmp_en_d;
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      thr_q        <= thr_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      sample_out_q <= sample_out_d;
      // A clear in the same cycle as an increment leaves the count at zero.
      if (clr_cnt) begin
        clip_cnt <= '0;
      end else if (inc && (clip_cnt != '1)) begin
        clip_cnt <= clip_cnt + CNT_W'(1);
      end
      if (clr_cnt) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.sample_out = sample_out_q;
  assign bus.cmp_en     = cmp_en_q;
  assign bus.cmp_a      = cmp_a_q;
  assign bus.cmp_b      = cmp_b_q;

endmodule
